// File: rtl/shifter_16b_checker.sv
// Response checker for the 16-bit barrel shifter: recomputes each applied vector's
// result, compares it with the shifter output and keeps pass/fail statistics.
module shifter_16b_checker #(
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_valid,
    input  logic [15:0]      chk_in,
    input  logic [1:0]       chk_op,
    input  logic [3:0]       chk_shift,
    input  logic [15:0]      chk_out,
    input  logic             chk_last,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [15:0]      ff_in,
    output logic [1:0]       ff_op,
    output logic [3:0]       ff_shift,
    output logic [15:0]      ff_out,
    output logic [15:0]      ff_exp,
    output logic [2:0]       dbg_state
);

    // Handshake: chk_valid is a one-way strobe with no ready. A vector is taken on
    // every edge where chk_valid=1 and the checker is IDLE, RUN or DRAIN; chk_last
    // only has meaning together with chk_valid. DONE and HALT drop vectors silently.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state_q;
    state_t state_d;

    // stage 1: captured vector
    logic        s1_valid;
    logic [15:0] s1_in;
    logic [1:0]  s1_op;
    logic [3:0]  s1_shift;
    logic [15:0] s1_out;

    // stage 2: expected value and verdict
    logic        s2_valid;
    logic        s2_mis;
    logic [15:0] s2_in;
    logic [1:0]  s2_op;
    logic [3:0]  s2_shift;
    logic [15:0] s2_out;
    logic [15:0] s2_exp;

    logic        accept;
    logic        halt_now;
    logic [31:0] dbl_rol;
    logic [31:0] dbl_ror;
    logic [15:0] exp_val;

    assign accept   = chk_valid &&
                      ((state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_DRAIN));
    assign halt_now = STOP_ON_ERR && s2_valid && s2_mis;

    // Rotates come from shifting the doubled word; both halves carry the wrap-around bits.
    assign dbl_rol = {s1_in, s1_in} << s1_shift;
    assign dbl_ror = {s1_in, s1_in} >> s1_shift;

    always_comb begin
        exp_val = s1_in;
        case (s1_op)
            2'b00:   exp_val = dbl_rol[31:16];
            2'b01:   exp_val = s1_in << s1_shift;
            2'b10:   exp_val = dbl_ror[15:0];
            default: exp_val = s1_in >> s1_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (chk_valid) begin
                    state_d = chk_last ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (chk_valid && chk_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!s1_valid && !s2_valid && !chk_valid) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = state_q;
        endcase
        if (halt_now) begin
            state_d = S_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A halting mismatch discards whatever is still in flight, including a vector
    // arriving on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_in    <= '0;
            s1_op    <= '0;
            s1_shift <= '0;
            s1_out   <= '0;
        end else begin
            s1_valid <= accept && !halt_now;
            if (accept) begin
                s1_in    <= chk_in;
                s1_op    <= chk_op;
                s1_shift <= chk_shift;
                s1_out   <= chk_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_mis   <= 1'b0;
            s2_in    <= '0;
            s2_op    <= '0;
            s2_shift <= '0;
            s2_out   <= '0;
            s2_exp   <= '0;
        end else begin
            s2_valid <= s1_valid && !halt_now;
            if (s1_valid) begin
                s2_mis   <= (s1_out != exp_val);
                s2_in    <= s1_in;
                s2_op    <= s1_op;
                s2_shift <= s1_shift;
                s2_out   <= s1_out;
                s2_exp   <= exp_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            err      <= 1'b0;
            ff_in    <= '0;
            ff_op    <= '0;
            ff_shift <= '0;
            ff_out   <= '0;
            ff_exp   <= '0;
        end else if (s2_valid) begin
            if (!s2_mis) begin
                if (pass_cnt != CNT_MAX) begin
                    pass_cnt <= pass_cnt + CNT_ONE;
                end
            end else begin
                if (fail_cnt != CNT_MAX) begin
                    fail_cnt <= fail_cnt + CNT_ONE;
                end
                err <= 1'b1;
                // only the first failure since reset is kept for post-mortem
                if (!err) begin
                    ff_in    <= s2_in;
                    ff_op    <= s2_op;
                    ff_shift <= s2_shift;
                    ff_out   <= s2_out;
                    ff_exp   <= s2_exp;
                end
            end
        end
    end

    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN) || s1_valid || s2_valid;
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_shifter_16b_checker.sv
// Bench for shifter_16b_checker: three instances (default, stop-on-error, 2-bit
// counters) checked every cycle against an event-level reference model.
module tb_shifter_16b_checker;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;
    localparam int P_HALT  = 4;

    typedef struct {
        int          inst;
        longint      due;
        logic        mis;
        logic [15:0] din;
        logic [1:0]  op;
        logic [3:0]  sh;
        logic [15:0] dout;
        logic [15:0] exp;
    } ent_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // stimulus per instance
    logic        v[3];
    logic [15:0] di[3];
    logic [1:0]  dop[3];
    logic [3:0]  dsh[3];
    logic [15:0] dout[3];
    logic        dlast[3];

    // observed outputs
    logic        o_busy[3];
    logic        o_done[3];
    logic        o_err[3];
    logic [15:0] o_fin[3];
    logic [1:0]  o_fop[3];
    logic [3:0]  o_fsh[3];
    logic [15:0] o_fout[3];
    logic [15:0] o_fexp[3];
    logic [2:0]  o_st[3];
    logic [15:0] pc0, fc0, pc1, fc1;
    logic [1:0]  pc2, fc2;

    shifter_16b_checker #(.CNT_W(16), .STOP_ON_ERR(1'b0)) u_main (
        .clk(clk), .rst(rst), .chk_valid(v[0]), .chk_in(di[0]), .chk_op(dop[0]),
        .chk_shift(dsh[0]), .chk_out(dout[0]), .chk_last(dlast[0]),
        .busy(o_busy[0]), .done(o_done[0]), .err(o_err[0]), .pass_cnt(pc0), .fail_cnt(fc0),
        .ff_in(o_fin[0]), .ff_op(o_fop[0]), .ff_shift(o_fsh[0]), .ff_out(o_fout[0]),
        .ff_exp(o_fexp[0]), .dbg_state(o_st[0])
    );

    shifter_16b_checker #(.CNT_W(16), .STOP_ON_ERR(1'b1)) u_halt (
        .clk(clk), .rst(rst), .chk_valid(v[1]), .chk_in(di[1]), .chk_op(dop[1]),
        .chk_shift(dsh[1]), .chk_out(dout[1]), .chk_last(dlast[1]),
        .busy(o_busy[1]), .done(o_done[1]), .err(o_err[1]), .pass_cnt(pc1), .fail_cnt(fc1),
        .ff_in(o_fin[1]), .ff_op(o_fop[1]), .ff_shift(o_fsh[1]), .ff_out(o_fout[1]),
        .ff_exp(o_fexp[1]), .dbg_state(o_st[1])
    );

    shifter_16b_checker #(.CNT_W(2), .STOP_ON_ERR(1'b0)) u_sat (
        .clk(clk), .rst(rst), .chk_valid(v[2]), .chk_in(di[2]), .chk_op(dop[2]),
        .chk_shift(dsh[2]), .chk_out(dout[2]), .chk_last(dlast[2]),
        .busy(o_busy[2]), .done(o_done[2]), .err(o_err[2]), .pass_cnt(pc2), .fail_cnt(fc2),
        .ff_in(o_fin[2]), .ff_op(o_fop[2]), .ff_shift(o_fsh[2]), .ff_out(o_fout[2]),
        .ff_exp(o_fexp[2]), .dbg_state(o_st[2])
    );

    function automatic logic [15:0] dut_pass(input int n);
        case (n)
            0:       return pc0;
            1:       return pc1;
            default: return {14'b0, pc2};
        endcase
    endfunction

    function automatic logic [15:0] dut_fail(input int n);
        case (n)
            0:       return fc0;
            1:       return fc1;
            default: return {14'b0, fc2};
        endcase
    endfunction

    // reference shifter: one bit position per step
    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] op,
                                              input logic [3:0] sh);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < int'(sh); i++) begin
            case (op)
                2'b00:   r = {r[14:0], r[15]};
                2'b01:   r = {r[14:0], 1'b0};
                2'b10:   r = {r[0], r[15:1]};
                default: r = {1'b0, r[15:1]};
            endcase
        end
        return r;
    endfunction

    // scoreboard / model state
    int          n_checks = 0;
    int          n_err    = 0;
    bit          chk_en   = 1'b0;
    longint      cyc      = 0;
    ent_t        pend_q[$];
    logic [15:0] exp_q[$];
    int          m_phase[3];
    logic [15:0] m_pass[3];
    logic [15:0] m_fail[3];
    logic        m_err[3];
    logic [15:0] m_fin[3];
    logic [1:0]  m_fop[3];
    logic [3:0]  m_fsh[3];
    logic [15:0] m_fout[3];
    logic [15:0] m_fexp[3];
    int          cnt_max[3] = '{65535, 65535, 3};
    bit          stop_cfg[3] = '{1'b0, 1'b1, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit has_pend(input int n);
        foreach (pend_q[i]) if (pend_q[i].inst == n) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drop_pend(input int n);
        for (int i = pend_q.size() - 1; i >= 0; i--) begin
            if (pend_q[i].inst == n) pend_q.delete(i);
        end
    endtask

    task automatic model_edge(input int n);
        ent_t e;
        bit   halt_now;
        halt_now = 1'b0;
        if (rst) begin
            m_phase[n] = P_IDLE;
            m_pass[n] = '0; m_fail[n] = '0; m_err[n] = 1'b0;
            m_fin[n] = '0; m_fop[n] = '0; m_fsh[n] = '0; m_fout[n] = '0; m_fexp[n] = '0;
            drop_pend(n);
            return;
        end
        if (m_phase[n] == P_DRAIN && !has_pend(n) && !v[n]) m_phase[n] = P_DONE;
        // a vector accepted two edges ago is scored now
        for (int i = 0; i < pend_q.size(); i++) begin
            if (pend_q[i].inst == n && pend_q[i].due == cyc) begin
                e = pend_q[i];
                pend_q.delete(i);
                if (!e.mis) begin
                    if (int'(m_pass[n]) < cnt_max[n]) m_pass[n]++;
                end else begin
                    if (int'(m_fail[n]) < cnt_max[n]) m_fail[n]++;
                    if (!m_err[n]) begin
                        m_fin[n] = e.din; m_fop[n] = e.op; m_fsh[n] = e.sh;
                        m_fout[n] = e.dout; m_fexp[n] = e.exp;
                    end
                    m_err[n] = 1'b1;
                    if (stop_cfg[n]) halt_now = 1'b1;
                end
                break;
            end
        end
        if (halt_now) begin
            drop_pend(n);
            m_phase[n] = P_HALT;
        end
        if (v[n] && !halt_now && (m_phase[n] inside {P_IDLE, P_RUN, P_DRAIN})) begin
            e.inst = n; e.due = cyc + 2;
            e.din = di[n]; e.op = dop[n]; e.sh = dsh[n]; e.dout = dout[n];
            e.exp = ref_shift(di[n], dop[n], dsh[n]);
            e.mis = (dout[n] != e.exp);
            pend_q.push_back(e);
            if (dlast[n]) m_phase[n] = P_DRAIN;
            else if (m_phase[n] == P_IDLE) m_phase[n] = P_RUN;
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int n = 0; n < 3; n++) model_edge(n);
    end

    // per-cycle comparison of every instance against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int n = 0; n < 3; n++) begin
                check($sformatf("i%0d pass_cnt", n), dut_pass(n), m_pass[n]);
                check($sformatf("i%0d fail_cnt", n), dut_fail(n), m_fail[n]);
                check($sformatf("i%0d err", n), o_err[n], m_err[n]);
                check($sformatf("i%0d busy", n), o_busy[n],
                      (m_phase[n] == P_RUN) || (m_phase[n] == P_DRAIN) || has_pend(n));
                check($sformatf("i%0d done", n), o_done[n], m_phase[n] == P_DONE);
                check($sformatf("i%0d ff_in", n), o_fin[n], m_fin[n]);
                check($sformatf("i%0d ff_op", n), o_fop[n], m_fop[n]);
                check($sformatf("i%0d ff_shift", n), o_fsh[n], m_fsh[n]);
                check($sformatf("i%0d ff_out", n), o_fout[n], m_fout[n]);
                check($sformatf("i%0d ff_exp", n), o_fexp[n], m_fexp[n]);
            end
        end
    end

    // driver tasks
    task automatic drive(input int n, input logic [15:0] d, input logic [1:0] op,
                         input logic [3:0] sh, input logic [15:0] o, input logic last);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            v[k] = 1'b0;
            dlast[k] = 1'b0;
        end
        v[n] = 1'b1; di[n] = d; dop[n] = op; dsh[n] = sh; dout[n] = o; dlast[n] = last;
    endtask

    task automatic idle();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            v[k] = 1'b0;
            dlast[k] = 1'b0;
        end
    endtask

    task automatic reset_all();
        @(negedge clk);
        for (int k = 0; k < 3; k++) v[k] = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pin_in[8]  = '{16'h8001, 16'hF00F, 16'hF00F, 16'hF00F,
                                    16'hF00F, 16'hFFFF, 16'hF00F, 16'h00FF};
        logic [1:0]  pin_op[8]  = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1};
        logic [3:0]  pin_sh[8]  = '{4'd1, 4'd4, 4'd4, 4'd4, 4'd4, 4'd15, 4'd0, 4'd4};
        logic [15:0] pin_exp[8] = '{16'h0003, 16'h00FF, 16'h00F0, 16'hFF00,
                                    16'h0F00, 16'h0001, 16'hF00F, 16'h0FF0};
        logic [15:0] r_in, r_out;
        logic [1:0]  r_op;
        logic [3:0]  r_sh;
        int          waited;

        for (int k = 0; k < 3; k++) begin
            v[k] = 1'b0; di[k] = '0; dop[k] = '0; dsh[k] = '0; dout[k] = '0; dlast[k] = 1'b0;
        end

        // pin the reference shifter to hand-computed results
        for (int i = 0; i < 8; i++) exp_q.push_back(pin_exp[i]);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ref_shift pin %0d", i), ref_shift(pin_in[i], pin_op[i], pin_sh[i]),
                  exp_q.pop_front());
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b0;

        // reset then idle
        repeat (10) idle();
        check("idle busy", o_busy[0], 1'b0);
        check("idle done", o_done[0], 1'b0);
        check("idle err", o_err[0], 1'b0);
        check("idle pass", pc0, 16'd0);
        check("idle fail", fc0, 16'd0);
        check("idle ff_exp", o_fexp[0], 16'd0);
        check("idle state", o_st[0], 3'd0);

        // single last vector: counted two edges after sampling, done one edge later
        drive(0, 16'h8001, 2'b00, 4'd1, 16'h0003, 1'b1);
        idle();
        check("single pass after E0", pc0, 16'd0);
        idle();
        check("single pass after E1", pc0, 16'd0);
        idle();
        check("single pass after E2", pc0, 16'd1);
        check("single done after E2", o_done[0], 1'b0);
        idle();
        check("single done after E3", o_done[0], 1'b1);
        check("single err", o_err[0], 1'b0);

        // all four ops on 0xF00F by 4, then shift 0
        reset_all();
        drive(0, 16'hF00F, 2'b00, 4'd4, 16'h00FF, 1'b0);
        drive(0, 16'hF00F, 2'b01, 4'd4, 16'h00F0, 1'b0);
        drive(0, 16'hF00F, 2'b10, 4'd4, 16'hFF00, 1'b0);
        drive(0, 16'hF00F, 2'b11, 4'd4, 16'h0F00, 1'b0);
        idle(); idle(); idle();
        check("ops pass", pc0, 16'd4);
        check("ops fail", fc0, 16'd0);
        drive(0, 16'hF00F, 2'b11, 4'd0, 16'hF00F, 1'b0);
        idle(); idle(); idle();
        check("shift0 pass", pc0, 16'd5);

        // two mismatches: only the first is captured
        drive(0, 16'hFFFF, 2'b11, 4'd15, 16'h0003, 1'b0);
        drive(0, 16'h1234, 2'b00, 4'd0, 16'h0000, 1'b0);
        idle(); idle(); idle();
        check("mis err", o_err[0], 1'b1);
        check("mis fail", fc0, 16'd2);
        check("mis ff_in", o_fin[0], 16'hFFFF);
        check("mis ff_op", o_fop[0], 2'b11);
        check("mis ff_shift", o_fsh[0], 4'hF);
        check("mis ff_out", o_fout[0], 16'h0003);
        check("mis ff_exp", o_fexp[0], 16'h0001);

        // randomized traffic with bubbles and occasional wrong results
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                r_in = 16'($urandom);
                r_op = 2'($urandom_range(0, 3));
                r_sh = 4'($urandom_range(0, 15));
                r_out = ($urandom_range(0, 4) == 0) ? 16'($urandom) : ref_shift(r_in, r_op, r_sh);
                drive(0, r_in, r_op, r_sh, r_out, 1'b0);
            end
        end
        drive(0, 16'h0F0F, 2'b10, 4'd8, 16'h0F0F, 1'b1);
        waited = 0;
        do begin
            idle();
            waited++;
        end while (!o_done[0] && waited < 20);
        check("random drain done", o_done[0], 1'b1);
        drive(0, 16'h0001, 2'b01, 4'd1, 16'h0002, 1'b1);
        idle(); idle(); idle();
        check("done ignores vectors", o_done[0], 1'b1);

        // stop-on-error: bad vector then two good ones back to back
        reset_all();
        drive(1, 16'h00FF, 2'b01, 4'd4, 16'h0000, 1'b0);
        drive(1, 16'h0001, 2'b00, 4'd1, 16'h0002, 1'b0);
        drive(1, 16'h8000, 2'b11, 4'd15, 16'h0001, 1'b0);
        repeat (5) idle();
        check("halt fail", fc1, 16'd1);
        check("halt pass", pc1, 16'd0);
        check("halt busy", o_busy[1], 1'b0);
        check("halt done", o_done[1], 1'b0);
        check("halt ff_exp", o_fexp[1], 16'h0FF0);
        drive(1, 16'h0001, 2'b00, 4'd1, 16'h0002, 1'b1);
        repeat (4) idle();
        check("halt ignores vectors", pc1, 16'd0);

        // 2-bit counters saturate; reset in the middle of DRAIN
        reset_all();
        for (int i = 0; i < 5; i++) begin
            r_in = 16'($urandom);
            r_op = 2'($urandom_range(0, 3));
            r_sh = 4'($urandom_range(0, 15));
            drive(2, r_in, r_op, r_sh, ref_shift(r_in, r_op, r_sh), i == 4);
        end
        idle();
        check("sat pass", {14'b0, pc2}, 16'd3);
        check("sat busy", o_busy[2], 1'b1);
        idle();
        check("sat pass held", {14'b0, pc2}, 16'd3);
        check("sat draining", o_done[2], 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("drain rst pass", {14'b0, pc2}, 16'd0);
        check("drain rst busy", o_busy[2], 1'b0);
        check("drain rst done", o_done[2], 1'b0);
        check("drain rst state", o_st[2], 3'd0);
        repeat (4) idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
